// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter and fetch-sequencing stage for KGP-RISC. Takes the
//   resolved jump decision from execute and produces the next fetch
//   address. It also drives the fetch handshake, pulses a pipeline flush on
//   taken branches, issues the ra write for bl, and keeps a saturating
//   taken-branch counter for debug.
//
// Ports
//   clk, rst      : clock and synchronous active-high reset
//   fetch_ready   : instruction memory accepts pc this cycle
//   br_valid      : execute holds a resolved branch-class instruction
//   validJump     : jump decision for that instruction
//   opcode        : opcode of the instruction in execute
//   br_pc         : PC of the instruction in execute
//   reg_target    : register target used by br
//   offset        : signed byte offset for PC-relative branches
//   halt_req      : execute holds a halt instruction
//   pc            : current fetch address
//   fetch_valid   : pc is a valid fetch request
//   flush         : one-cycle squash of younger in-flight instructions
//   link_we       : one-cycle write enable for ra (r31)
//   link_addr     : return address written on link_we
//   misalign      : one-cycle pulse when the branch target had low bits set
//   halted        : sequencer is halted
//   taken_cnt     : saturating count of taken branches
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 4,
  parameter int                OFF_W    = 26,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_ready,
  input  logic              br_valid,
  input  logic              validJump,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic [OFF_W-1:0]  offset,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              misalign,
  output logic              halted,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [5:0]        OP_BR = 6'b001010;
  localparam logic [5:0]        OP_BL = 6'b001100;
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIRECT,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

  // Branch target arithmetic; wraps naturally modulo 2^ADDR_W.
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] target;

  assign off_ext  = ADDR_W'($signed(offset));
  assign ret_addr = br_pc + INC;
  assign target   = (opcode == OP_BR) ? reg_target : (ret_addr + off_ext);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_d     = 1'b0;
    link_we_d   = 1'b0;
    link_addr_d = link_addr_q;
    misalign_d  = 1'b0;
    taken_cnt_d = taken_cnt_q;

    unique case (state_q)
      S_BOOT:     state_d = S_RUN;
      // The instruction in execute during REDIRECT is on the squashed path.
      S_REDIRECT: state_d = S_RUN;
      S_HALT:     state_d = S_HALT;
      S_RUN: begin
        if (halt_req) begin
          // Halt wins over any branch in the same cycle.
          state_d = S_HALT;
        end else if (br_valid && validJump) begin
          state_d    = S_REDIRECT;
          pc_d       = {target[ADDR_W-1:2], 2'b00};
          misalign_d = (target[1:0] != 2'b00);
          flush_d    = 1'b1;
          if (taken_cnt_q != '1) begin
            taken_cnt_d = taken_cnt_q + 1'b1;
          end
          if (opcode == OP_BL) begin
            link_we_d   = 1'b1;
            link_addr_d = ret_addr;
          end
        end else if (fetch_ready) begin
          pc_d = pc_q + INC;
        end
      end
      default:    state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      flush_q     <= 1'b0;
      link_we_q   <= 1'b0;
      link_addr_q <= '0;
      misalign_q  <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
      misalign_q  <= misalign_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign flush       = flush_q;
  assign link_we     = link_we_q;
  assign link_addr   = link_addr_q;
  assign misalign    = misalign_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed vector table, a few hand-written sequences and a randomized run
//   for pc_sequencer. The counter is narrowed so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready;
  logic        br_valid;
  logic        validJump;
  logic [5:0]  opcode;
  logic [31:0] br_pc;
  logic [31:0] reg_target;
  logic [25:0] offset;
  logic        halt_req;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        link_we;
  logic [31:0] link_addr;
  logic        misalign;
  logic        halted;
  logic [CNT_W-1:0] taken_cnt;

  pc_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .br_valid(br_valid),
    .validJump(validJump), .opcode(opcode), .br_pc(br_pc),
    .reg_target(reg_target), .offset(offset), .halt_req(halt_req),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .link_we(link_we),
    .link_addr(link_addr), .misalign(misalign), .halted(halted),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural reference model ----------------
  // Tracks "what the machine is doing" as independent flags and applies
  // the architectural rules with plain 64-bit arithmetic.
  logic [31:0] m_pc, m_la;
  bit          m_booting, m_redirecting, m_halted, m_flush, m_lw, m_mis;
  int          m_cnt;

  task automatic model_step();
    longint t;
    longint soff;
    if (rst) begin
      m_pc = 32'h0; m_booting = 1; m_redirecting = 0; m_halted = 0;
      m_flush = 0; m_lw = 0; m_la = 32'h0; m_mis = 0; m_cnt = 0;
      return;
    end
    m_flush = 0; m_lw = 0; m_mis = 0;
    if (m_booting)          m_booting = 0;
    else if (m_redirecting) m_redirecting = 0;
    else if (m_halted)      ;
    else if (halt_req)      m_halted = 1;
    else if (br_valid && validJump) begin
      soff = $signed(offset);
      if (opcode == 6'd10) t = longint'(reg_target);
      else t = (longint'(br_pc) + 4 + soff) & 64'hFFFF_FFFF;
      m_pc  = 32'(t - (t % 4));
      m_mis = (t % 4) != 0;
      m_flush = 1;
      m_redirecting = 1;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (opcode == 6'd12) begin
        m_lw = 1;
        m_la = 32'((longint'(br_pc) + 4) & 64'hFFFF_FFFF);
      end
    end else if (fetch_ready) begin
      m_pc = 32'((longint'(m_pc) + 4) & 64'hFFFF_FFFF);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(bit r, bit fr, bit bv, bit vj, logic [5:0] op,
                        logic [31:0] bpc, logic [31:0] rt, logic [25:0] off,
                        bit hr);
    rst = r; fetch_ready = fr; br_valid = bv; validJump = vj; opcode = op;
    br_pc = bpc; reg_target = rt; offset = off; halt_req = hr;
  endtask

  // One clock edge: update the model, then compare every output to it.
  task automatic step(string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".pc"},        pc,                 m_pc);
    chk({tag, ".fv"},        32'(fetch_valid),   32'(!m_booting && !m_redirecting && !m_halted));
    chk({tag, ".flush"},     32'(flush),         32'(m_flush));
    chk({tag, ".link_we"},   32'(link_we),       32'(m_lw));
    chk({tag, ".link_addr"}, link_addr,          m_la);
    chk({tag, ".misalign"},  32'(misalign),      32'(m_mis));
    chk({tag, ".halted"},    32'(halted),        32'(m_halted));
    chk({tag, ".cnt"},       32'(taken_cnt),     32'(m_cnt));
    $display("%s rst=%0b fr=%0b bv=%0b vj=%0b op=%b hr=%0b -> pc=%h fv=%0b fl=%0b lw=%0b la=%h mis=%0b h=%0b cnt=%0d",
             tag, rst, fetch_ready, br_valid, validJump, opcode, halt_req,
             pc, fetch_valid, flush, link_we, link_addr, misalign, halted, taken_cnt);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          r, fr, bv, vj, hr;
    logic [5:0]  op;
    logic [31:0] bpc, rt;
    logic [25:0] off;
    logic [31:0] e_pc, e_la;
    bit          e_fv, e_fl, e_lw, e_mis, e_h;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(bit r, bit fr, bit bv, bit vj, logic [5:0] op,
                             logic [31:0] bpc, logic [31:0] rt, logic [25:0] off, bit hr,
                             logic [31:0] e_pc, bit e_fv, bit e_fl, bit e_lw,
                             logic [31:0] e_la, bit e_mis, bit e_h, int e_cnt);
    vec_t v;
    v.r = r; v.fr = fr; v.bv = bv; v.vj = vj; v.op = op; v.bpc = bpc; v.rt = rt;
    v.off = off; v.hr = hr; v.e_pc = e_pc; v.e_fv = e_fv; v.e_fl = e_fl;
    v.e_lw = e_lw; v.e_la = e_la; v.e_mis = e_mis; v.e_h = e_h; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    // reset then run
    tbl.push_back(V(1,1,0,0,0,0,0,0,0,  32'h0,  0,0,0,0,   0,0,0));
    tbl.push_back(V(1,1,0,0,0,0,0,0,0,  32'h0,  0,0,0,0,   0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,0,0,0,  32'h0,  1,0,0,0,   0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,0,0,0,  32'h4,  1,0,0,0,   0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,0,0,0,  32'h8,  1,0,0,0,   0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,0,0,0,  32'hC,  1,0,0,0,   0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,0,0,0,  32'h10, 1,0,0,0,   0,0,0));
    // stall at 0x10
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,  32'h10, 1,0,0,0,   0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,  32'h10, 1,0,0,0,   0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,  32'h10, 1,0,0,0,   0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,0,0,0,  32'h14, 1,0,0,0,   0,0,0));
    // taken b, offset -8 from 0x20
    tbl.push_back(V(0,1,1,1,6'd0,32'h20,0,26'h3FF_FFF8,0, 32'h1C, 0,1,0,0, 0,0,1));
    tbl.push_back(V(0,1,0,0,0,0,0,0,0,  32'h1C, 1,0,0,0,   0,0,1));
    // bl then br with misaligned register target
    tbl.push_back(V(0,1,1,1,6'd12,32'h40,0,26'h100,0, 32'h144, 0,1,1,32'h44, 0,0,2));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,  32'h144,1,0,0,32'h44, 0,0,2));
    tbl.push_back(V(0,1,1,1,6'd10,0,32'h47,0,0, 32'h44, 0,1,0,32'h44, 1,0,3));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,  32'h44, 1,0,0,32'h44, 0,0,3));
    // not taken, then a taken branch masked by REDIRECT
    tbl.push_back(V(0,1,1,0,6'd0,32'h44,0,26'h40,0, 32'h48, 1,0,0,32'h44, 0,0,3));
    tbl.push_back(V(0,1,1,1,6'd0,32'h100,0,0,0,   32'h104,0,1,0,32'h44, 0,0,4));
    tbl.push_back(V(0,1,1,1,6'd0,32'h200,0,0,0,   32'h104,1,0,0,32'h44, 0,0,4));
    // halt beats a simultaneous taken bl; halted ignores everything
    tbl.push_back(V(0,1,1,1,6'd12,32'h300,0,0,1,  32'h104,0,0,0,32'h44, 0,1,4));
    tbl.push_back(V(0,1,1,1,6'd12,32'h300,0,0,0,  32'h104,0,0,0,32'h44, 0,1,4));
    // reset out of HALT, then wrap at the top of the address space
    tbl.push_back(V(1,1,0,0,0,0,0,0,0,  32'h0, 0,0,0,0, 0,0,0));
    tbl.push_back(V(0,1,0,0,0,0,0,0,0,  32'h0, 1,0,0,0, 0,0,0));
    tbl.push_back(V(0,1,1,1,6'd10,0,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC,0,1,0,0, 0,0,1));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,  32'hFFFF_FFFC,1,0,0,0, 0,0,1));
    tbl.push_back(V(0,1,0,0,0,0,0,0,0,  32'h0, 1,0,0,0, 0,0,1));
  end

  // ---------------- stimulus ----------------
  initial begin
    string tag;
    set_in(1,0,0,0,0,0,0,0,0);
    #2;

    foreach (tbl[k]) begin
      set_in(tbl[k].r, tbl[k].fr, tbl[k].bv, tbl[k].vj, tbl[k].op,
             tbl[k].bpc, tbl[k].rt, tbl[k].off, tbl[k].hr);
      tag = $sformatf("vec%0d", k);
      step(tag);
      chk({tag, ".tbl_pc"},   pc,               tbl[k].e_pc);
      chk({tag, ".tbl_fv"},   32'(fetch_valid), 32'(tbl[k].e_fv));
      chk({tag, ".tbl_fl"},   32'(flush),       32'(tbl[k].e_fl));
      chk({tag, ".tbl_lw"},   32'(link_we),     32'(tbl[k].e_lw));
      chk({tag, ".tbl_la"},   link_addr,        tbl[k].e_la);
      chk({tag, ".tbl_mis"},  32'(misalign),    32'(tbl[k].e_mis));
      chk({tag, ".tbl_h"},    32'(halted),      32'(tbl[k].e_h));
      chk({tag, ".tbl_cnt"},  32'(taken_cnt),   32'(tbl[k].e_cnt));
    end

    // Counter saturation: many taken branches, each followed by its REDIRECT.
    set_in(1,1,0,0,0,0,0,0,0); step("sat_rst");
    set_in(0,1,0,0,0,0,0,0,0); step("sat_boot");
    for (int n = 0; n < CNT_MAX + 5; n++) begin
      set_in(0,1,1,1,6'd0,32'(n * 16),0,26'h8,0); step($sformatf("sat_br%0d", n));
      set_in(0,1,0,0,0,0,0,0,0);                  step($sformatf("sat_rd%0d", n));
    end
    chk("sat.cnt_const", 32'(taken_cnt), 32'(CNT_MAX));

    // Reset landing on the REDIRECT cycle clears the pulses and the pc.
    set_in(0,1,1,1,6'd12,32'h500,0,26'h20,0); step("rr_br");
    set_in(1,1,0,0,0,0,0,0,0);               step("rr_rst");
    chk("rr.pc_const",    pc,             32'h0);
    chk("rr.flush_const", 32'(flush),     32'h0);

    // Randomized run against the model.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 2))
        0: op = 6'd10;
        1: op = 6'd12;
        default: op = 6'($urandom);
      endcase
      set_in($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, op,
             $urandom, $urandom, 26'($urandom), $urandom_range(0, 39) == 0);
      step($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
